// File: rtl/ysyx_22051013_axi_lsu_master_pkg.sv
// Shared definitions for the LSU AXI4-lite master and its behavioural memory slave:
// FSM state encoding, AXI response codes, access-size encodings and the alignment helper.
package ysyx_22051013_axi_lsu_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_WREQ,
    ST_WRESP,
    ST_DONE
  } lsu_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic addr_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    case (size)
      SIZE_H:  return addr_lo[0];
      SIZE_W:  return |addr_lo[1:0];
      SIZE_D:  return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22051013_axi_lsu_slave.sv
// Behavioural AXI4-lite memory slave used as the data-memory model for the LSU master.
// Ready on each address/data channel is delayed by a run-time configurable number of
// cycles; every response carries resp_cfg. One transaction at a time.
module ysyx_22051013_axi_lsu_slave
  import ysyx_22051013_axi_lsu_master_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STRB_W     = DATA_W / 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        ar_delay,
  input  logic [3:0]        aw_delay,
  input  logic [3:0]        w_delay,
  input  logic [1:0]        resp_cfg,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic              ar_valid,
  output logic              ar_ready,
  output logic [DATA_W-1:0] r_data,
  output logic [1:0]        r_resp,
  output logic              r_valid,
  input  logic              r_ready,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic [STRB_W-1:0] w_strb,
  input  logic              w_valid,
  output logic              w_ready,
  output logic [1:0]        b_resp,
  output logic              b_valid,
  input  logic              b_ready
);

  localparam int OFS = $clog2(STRB_W);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [3:0] ar_cnt, aw_cnt, w_cnt;
  logic aw_got, w_got;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic ar_hs, aw_hs, w_hs, wr_fire;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic unused_addr_bits;

  assign ar_ready = ar_valid & ~r_valid & (ar_cnt >= ar_delay);
  assign aw_ready = aw_valid & ~aw_got & ~b_valid & (aw_cnt >= aw_delay);
  assign w_ready  = w_valid & ~w_got & ~b_valid & (w_cnt >= w_delay);
  assign ar_hs    = ar_valid & ar_ready;
  assign aw_hs    = aw_valid & aw_ready;
  assign w_hs     = w_valid & w_ready;
  assign wr_fire  = (aw_got | aw_hs) & (w_got | w_hs);
  assign wr_addr  = aw_hs ? aw_addr : awaddr_q;
  assign wr_data  = w_hs ? w_data : wdata_q;
  assign wr_strb  = w_hs ? w_strb : wstrb_q;
  assign unused_addr_bits = ^{ar_addr, wr_addr};

  // Ready-delay counters: count cycles a valid has waited, restart after each handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent simulation.
    if (rst) begin
      ar_cnt <= '0;
      aw_cnt <= '0;
      w_cnt  <= '0;
    end else begin
      ar_cnt <= (ar_valid && !ar_ready && ar_cnt != 4'hF) ? ar_cnt + 4'd1 : (ar_hs ? 4'd0 : ar_cnt);
      aw_cnt <= (aw_valid && !aw_ready && aw_cnt != 4'hF) ? aw_cnt + 4'd1 : (aw_hs ? 4'd0 : aw_cnt);
      w_cnt  <= (w_valid && !w_ready && w_cnt != 4'hF) ? w_cnt + 4'd1 : (w_hs ? 4'd0 : w_cnt);
    end
  end

  // Read and write response channels plus the write-half bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_resp   <= RESP_OKAY;
      b_valid  <= 1'b0;
      b_resp   <= RESP_OKAY;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (r_valid && r_ready) r_valid <= 1'b0;
      if (ar_hs) begin
        r_valid <= 1'b1;
        r_data  <= mem[ar_addr[OFS +: DEPTH_LOG2]];
        r_resp  <= resp_cfg;
      end
      if (b_valid && b_ready) b_valid <= 1'b0;
      if (aw_hs) awaddr_q <= aw_addr;
      if (w_hs) begin
        wdata_q <= w_data;
        wstrb_q <= w_strb;
      end
      if (wr_fire) begin
        aw_got  <= 1'b0;
        w_got   <= 1'b0;
        b_valid <= 1'b1;
        b_resp  <= resp_cfg;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
    end
  end

  // Byte-masked memory write once both write halves have arrived.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; a memory is a RAM macro, and clearing it
    // would need a multi-cycle sequencer rather than a reset branch.
    if (wr_fire) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_strb[i]) mem[wr_addr[OFS +: DEPTH_LOG2]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/ysyx_22051013_axi_lsu_master.sv
// AXI4-lite data-side master behind the LSU stage. Converts one load/store request at a
// time into an AXI-lite read or write, raises ls_not_ready while busy and presents the
// result in DONE until the LS-WB register accepts it.
// Optional: define YSYX_22051013_LSU_MISALIGN_CHK_EN to reject size-misaligned requests
// without touching the bus (rsp_err=1, rsp_rdata=0).
module ysyx_22051013_axi_lsu_master
  import ysyx_22051013_axi_lsu_master_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  input  logic [1:0]        req_size,
  input  logic              ls_accept,
  output logic              ls_not_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ar_addr,
  output logic              ar_valid,
  input  logic              ar_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  input  logic              r_valid,
  output logic              r_ready,
  output logic [ADDR_W-1:0] aw_addr,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [DATA_W-1:0] w_data,
  output logic [STRB_W-1:0] w_strb,
  output logic              w_valid,
  input  logic              w_ready,
  input  logic [1:0]        b_resp,
  input  logic              b_valid,
  output logic              b_ready
);

  lsu_state_e state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic err_q;
  logic aw_done, w_done;
  logic misaligned;

`ifdef YSYX_22051013_LSU_MISALIGN_CHK_EN
  assign misaligned = addr_misaligned(req_addr[2:0], req_size);
`else
  logic unused_req_size;
  assign misaligned      = 1'b0;
  assign unused_req_size = ^req_size;
`endif

  // The bus always sees the latched request, never the live LSU inputs.
  assign ar_addr   = addr_q;
  assign aw_addr   = addr_q;
  assign w_data    = wdata_q;
  assign w_strb    = wstrb_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and channel handshake outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nxt    = state;
    ls_not_ready = 1'b0;
    rsp_valid    = 1'b0;
    ar_valid     = 1'b0;
    r_ready      = 1'b0;
    aw_valid     = 1'b0;
    w_valid      = 1'b0;
    b_ready      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          ls_not_ready = 1'b1;
          if (misaligned)   state_nxt = ST_DONE;
          else if (req_wen) state_nxt = ST_WREQ;
          else              state_nxt = ST_RADDR;
        end
      end
      ST_RADDR: begin
        ls_not_ready = 1'b1;
        ar_valid     = 1'b1;
        if (ar_ready) state_nxt = ST_RDATA;
      end
      ST_RDATA: begin
        ls_not_ready = 1'b1;
        r_ready      = 1'b1;
        if (r_valid) state_nxt = ST_DONE;
      end
      ST_WREQ: begin
        ls_not_ready = 1'b1;
        aw_valid     = ~aw_done;
        w_valid      = ~w_done;
        if ((aw_done | aw_ready) && (w_done | w_ready)) state_nxt = ST_WRESP;
      end
      ST_WRESP: begin
        ls_not_ready = 1'b1;
        b_ready      = 1'b1;
        if (b_valid) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (ls_accept) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, write-half tracking and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (misaligned) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        ST_RDATA: begin
          if (r_valid) begin
            rdata_q <= r_data;
            err_q   <= (r_resp != RESP_OKAY);
          end
        end
        ST_WREQ: begin
          if (aw_valid && aw_ready) aw_done <= 1'b1;
          if (w_valid && w_ready)   w_done  <= 1'b1;
        end
        ST_WRESP: begin
          if (b_valid) err_q <= (b_resp != RESP_OKAY);
        end
        ST_DONE: begin
          if (ls_accept) err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
